vend_controller: RTL and testbench

//  Transaction FSM that drives the inventory block's vend interface. Accumulates coin

---
 rtl/vend_controller.sv | 177 +++++++++++++++++
 tb/tb_vend_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending transaction controller: coin credit, item selection with stock/price
// check, single-cycle vend strobe, motor supervision with timeout, change return.
module vend_controller #(
    parameter int unsigned PRICE0        = 4,
    parameter int unsigned PRICE1        = 5,
    parameter int unsigned PRICE2        = 6,
    parameter int unsigned PRICE3        = 8,
    parameter int unsigned CREDIT_MAX    = 40,
    parameter int unsigned MOTOR_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       select_valid,
    input  logic [1:0] select_item,
    input  logic       cancel,
    input  logic       sold_out,
    input  logic       motor_done,
    input  logic       change_ack,
    output logic [1:0] item_select,
    output logic       vend_pulse,
    output logic       motor_start,
    output logic [7:0] credit,
    output logic       change_valid,
    output logic [7:0] change_amount,
    output logic       coin_reject,
    output logic       deny_sold_out,
    output logic       deny_funds,
    output logic       fault
);

    localparam int unsigned CNT_W = $clog2(MOTOR_TIMEOUT);

    typedef enum logic [1:0] {IDLE, CHECK, MOTOR, CHANGE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         credit_q, credit_d;
    logic [1:0]         item_q, item_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic               vend_pulse_q, vend_pulse_d;
    logic               motor_start_q, motor_start_d;
    logic               change_valid_q, change_valid_d;
    logic [7:0]         change_amount_q, change_amount_d;
    logic               coin_reject_q, coin_reject_d;
    logic               deny_sold_out_q, deny_sold_out_d;
    logic               deny_funds_q, deny_funds_d;

    logic [8:0]         coin_sum;
    logic               coin_ok;
    logic [7:0]         price;
    logic               funds_ok;

    function automatic logic [7:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = 8'(PRICE0);
            2'd1:    price_of = 8'(PRICE1);
            2'd2:    price_of = 8'(PRICE2);
            default: price_of = 8'(PRICE3);
        endcase
    endfunction

    function automatic logic [8:0] coin_units(input logic [1:0] v);
        case (v)
            2'd0:    coin_units = 9'd1;
            2'd1:    coin_units = 9'd2;
            2'd2:    coin_units = 9'd5;
            default: coin_units = 9'd20;
        endcase
    endfunction

    // Sum is formed in 9 bits so a coin on top of a large credit cannot wrap.
    assign coin_sum = {1'b0, credit_q} + coin_units(coin_value);
    assign coin_ok  = coin_valid && (state_q == IDLE) && (coin_sum <= 9'(CREDIT_MAX));
    assign price    = price_of(item_q);
    assign funds_ok = (credit_q >= price);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            credit_q        <= '0;
            item_q          <= '0;
            cnt_q           <= '0;
            fault_q         <= 1'b0;
            vend_pulse_q    <= 1'b0;
            motor_start_q   <= 1'b0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            coin_reject_q   <= 1'b0;
            deny_sold_out_q <= 1'b0;
            deny_funds_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            item_q          <= item_d;
            cnt_q           <= cnt_d;
            fault_q         <= fault_d;
            vend_pulse_q    <= vend_pulse_d;
            motor_start_q   <= motor_start_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            coin_reject_q   <= coin_reject_d;
            deny_sold_out_q <= deny_sold_out_d;
            deny_funds_q    <= deny_funds_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        item_d   = item_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE: begin
                if (coin_ok) credit_d = coin_sum[7:0];
                // cancel outranks a same-cycle selection even when there is nothing to refund
                if (cancel) begin
                    if (credit_q != '0) state_d = CHANGE;
                end else if (select_valid && !fault_q) begin
                    item_d  = select_item;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!sold_out && funds_ok) begin
                    credit_d = credit_q - price;
                    cnt_d    = '0;
                    state_d  = MOTOR;
                end else begin
                    state_d = IDLE;
                end
            end
            MOTOR: begin
                if (motor_done) begin
                    state_d = (credit_q != '0) ? CHANGE : IDLE;
                end else if (cnt_q == CNT_W'(MOTOR_TIMEOUT - 1)) begin
                    fault_d  = 1'b1;
                    credit_d = credit_q + price;
                    state_d  = CHANGE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHANGE: begin
                if (change_ack) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vend_pulse_d    = (state_q == CHECK) && !sold_out && funds_ok;
        deny_sold_out_d = (state_q == CHECK) && sold_out;
        deny_funds_d    = (state_q == CHECK) && !sold_out && !funds_ok;
        coin_reject_d   = coin_valid && !coin_ok;
        motor_start_d   = (state_d == MOTOR);
        change_valid_d  = (state_d == CHANGE);
        change_amount_d = change_valid_d ? credit_d : '0;
    end

    assign item_select   = item_q;
    assign vend_pulse    = vend_pulse_q;
    assign motor_start   = motor_start_q;
    assign credit        = credit_q;
    assign change_valid  = change_valid_q;
    assign change_amount = change_amount_q;
    assign coin_reject   = coin_reject_q;
    assign deny_sold_out = deny_sold_out_q;
    assign deny_funds    = deny_funds_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed plus randomized transaction bench for vend_controller, checked against
// a transaction-level credit/outcome model.
module tb_vend_controller;

    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid, select_valid, cancel, sold_out, motor_done, change_ack;
    logic [1:0] coin_value, select_item;
    logic [1:0] item_select;
    logic       vend_pulse, motor_start, change_valid, coin_reject;
    logic       deny_sold_out, deny_funds, fault;
    logic [7:0] credit, change_amount;

    int n_cmp = 0;
    int n_err = 0;

    int m_credit;
    int price_tab[4] = '{4, 5, 6, 8};

    vend_controller #(.MOTOR_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .select_valid(select_valid), .select_item(select_item),
        .cancel(cancel), .sold_out(sold_out), .motor_done(motor_done),
        .change_ack(change_ack),
        .item_select(item_select), .vend_pulse(vend_pulse), .motor_start(motor_start),
        .credit(credit), .change_valid(change_valid), .change_amount(change_amount),
        .coin_reject(coin_reject), .deny_sold_out(deny_sold_out),
        .deny_funds(deny_funds), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int units(input int v);
        case (v)
            0: return 1;
            1: return 2;
            2: return 5;
            default: return 20;
        endcase
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_item"}, 32'(item_select), 0);
        chk({tag, "_vend"}, 32'(vend_pulse), 0);
        chk({tag, "_motor"}, 32'(motor_start), 0);
        chk({tag, "_credit"}, 32'(credit), 0);
        chk({tag, "_chv"}, 32'(change_valid), 0);
        chk({tag, "_cha"}, 32'(change_amount), 0);
        chk({tag, "_rej"}, 32'(coin_reject), 0);
        chk({tag, "_dso"}, 32'(deny_sold_out), 0);
        chk({tag, "_dfu"}, 32'(deny_funds), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
    endtask

    task automatic coin(input int v);
        bit rej;
        rej = (m_credit + units(v)) > 40;
        coin_valid = 1'b1;
        coin_value = 2'(v);
        step();
        coin_valid = 1'b0;
        chk("coin_reject", 32'(coin_reject), 32'(rej));
        if (!rej) m_credit += units(v);
        chk("coin_credit", 32'(credit), 32'(m_credit));
    endtask

    task automatic do_select(input int item, input bit so, output bit vended);
        bit e_dso, e_dfu, e_vend;
        e_dso  = so;
        e_dfu  = !so && (m_credit < price_tab[item]);
        e_vend = !e_dso && !e_dfu;
        select_valid = 1'b1;
        select_item  = 2'(item);
        sold_out     = so;
        step();
        select_valid = 1'b0;
        chk("sel_item", 32'(item_select), 32'(item));
        chk("sel_early_vend", 32'(vend_pulse), 0);
        step();
        sold_out = 1'b0;
        chk("sel_dso", 32'(deny_sold_out), 32'(e_dso));
        chk("sel_dfu", 32'(deny_funds), 32'(e_dfu));
        chk("sel_vend", 32'(vend_pulse), 32'(e_vend));
        chk("sel_motor", 32'(motor_start), 32'(e_vend));
        if (e_vend) m_credit -= price_tab[item];
        chk("sel_credit", 32'(credit), 32'(m_credit));
        step();
        chk("sel_vend_1cyc", 32'(vend_pulse), 0);
        chk("sel_deny_1cyc", 32'(deny_sold_out | deny_funds), 0);
        vended = e_vend;
    endtask

    // Called one cycle into MOTOR (after the post-vend step of do_select).
    task automatic run_motor(input int delay, input bit coin_in);
        for (int i = 0; i < delay; i++) begin
            chk("motor_level", 32'(motor_start), 1);
            if (coin_in && i == 0) begin
                coin_valid = 1'b1;
                coin_value = 2'd3;
                step();
                coin_valid = 1'b0;
                chk("motor_coin_rej", 32'(coin_reject), 1);
                chk("motor_coin_credit", 32'(credit), 32'(m_credit));
            end else begin
                step();
            end
        end
        motor_done = 1'b1;
        step();
        motor_done = 1'b0;
        chk("done_motor_off", 32'(motor_start), 0);
        chk("done_chv", 32'(change_valid), 32'(m_credit > 0));
        if (m_credit > 0) chk("done_cha", 32'(change_amount), 32'(m_credit));
    endtask

    task automatic collect_change(input int wait_cyc);
        for (int i = 0; i < wait_cyc; i++) begin
            chk("chg_valid", 32'(change_valid), 1);
            chk("chg_amount", 32'(change_amount), 32'(m_credit));
            if (i == 0) cancel = 1'b1;
            step();
            cancel = 1'b0;
            chk("chg_frozen", 32'(credit), 32'(m_credit));
        end
        change_ack = 1'b1;
        step();
        change_ack = 1'b0;
        m_credit = 0;
        chk("ack_chv", 32'(change_valid), 0);
        chk("ack_credit", 32'(credit), 0);
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_chv", 32'(change_valid), 32'(m_credit > 0));
        if (m_credit > 0) chk("cancel_cha", 32'(change_amount), 32'(m_credit));
    endtask

    initial begin
        bit vended;
        int steps;
        int pre;
        rst_n = 1'b0;
        coin_valid = 0; coin_value = 0; select_valid = 0; select_item = 0;
        cancel = 0; sold_out = 0; motor_done = 0; change_ack = 0;
        m_credit = 0;
        repeat (3) step();
        check_zero("reset");
        rst_n = 1'b1;
        step();

        // 25c + 25c, buy item1, change 5
        coin(2); coin(2);
        do_select(1, 0, vended);
        chk("t1_vended", 32'(vended), 1);
        chk("t1_credit5", 32'(credit), 5);
        run_motor(3, 1);
        collect_change(2);

        // insufficient funds
        coin(0); coin(1);
        do_select(0, 0, vended);
        chk("t2_credit3", 32'(credit), 3);
        do_cancel();
        collect_change(1);

        // sold out
        coin(3);
        do_select(2, 1, vended);
        chk("t3_credit20", 32'(credit), 20);
        do_cancel();
        collect_change(0);

        // credit ceiling: 38 + $1 refused
        coin(3); coin(2); coin(2); coin(2); coin(0); coin(1);
        chk("t4_credit38", 32'(credit), 38);
        coin(3);
        chk("t4_still38", 32'(credit), 38);
        do_cancel();
        collect_change(1);

        // cancel with zero credit is ignored
        do_cancel();

        for (int t = 0; t < 40; t++) begin
            int nc;
            nc = $urandom_range(0, 4);
            for (int c = 0; c < nc; c++) coin($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                do_cancel();
                if (m_credit > 0) collect_change($urandom_range(0, 3));
            end else begin
                do_select($urandom_range(0, 3), ($urandom_range(0, 3) == 0), vended);
                if (vended) begin
                    run_motor($urandom_range(0, TO - 4), 1'($urandom_range(0, 1)));
                    if (m_credit > 0) collect_change($urandom_range(0, 3));
                end
            end
        end

        // motor timeout: refund of price, sticky fault, selections ignored
        coin(3);
        pre = m_credit;
        do_select(3, 0, vended);
        steps = 1;
        while (fault !== 1'b1 && steps < int'(TO) + 5) begin
            step();
            steps++;
        end
        chk("to_cycles", 32'(steps), 32'(TO));
        chk("to_fault", 32'(fault), 1);
        m_credit += price_tab[3];
        chk("to_chv", 32'(change_valid), 1);
        chk("to_cha_prevend", 32'(change_amount), 32'(pre));
        collect_change(2);
        coin(3);
        select_valid = 1'b1;
        select_item  = 2'd0;
        step();
        select_valid = 1'b0;
        chk("flt_item_kept", 32'(item_select), 3);
        step();
        chk("flt_no_vend", 32'(vend_pulse), 0);
        chk("flt_no_deny", 32'(deny_funds | deny_sold_out), 0);
        chk("flt_no_motor", 32'(motor_start), 0);
        chk("flt_credit", 32'(credit), 32'(m_credit));
        chk("flt_sticky", 32'(fault), 1);
        do_cancel();
        collect_change(1);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_credit = 0;
        check_zero("flt_reset");
        step();

        // async reset in the middle of MOTOR
        coin(3);
        do_select(1, 0, vended);
        step(); step();
        chk("mid_motor", 32'(motor_start), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        step();
        rst_n = 1'b1;
        m_credit = 0;
        step();
        check_zero("post_reset");

        coin(2); coin(2);
        do_select(3, 0, vended);
        chk("post_vended", 32'(vended), 1);
        run_motor(2, 0);
        collect_change(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
